// File: rtl/t03_text_pkg.sv
// ============================================================================
//  Module   : t03_text_pkg
//  Purpose  : Shared constants, FSM state type and glyph helpers for the
//             text rasterizer (line geometry, glyph slicing, backspace code).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package t03_text_pkg;

    localparam int CHARS      = 18;                 // character cells per line
    localparam int CELL_W     = 6;                  // 5 glyph columns + spacer
    localparam int ROWS       = 8;                  // pixel rows per line
    localparam int GLYPH_W    = 5;                  // glyph columns
    localparam int LINE_W     = CHARS * CELL_W;     // 108 pixel columns
    localparam int TEXT_W     = LINE_W * ROWS;      // 864-bit bitmap
    localparam int GLYPH_BITS = GLYPH_W * ROWS;     // 40-bit ROM word
    localparam int CUR_W      = $clog2(CHARS + 1);  // cursor counts 0..CHARS

    localparam logic [7:0] BS_CODE = 8'h08;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RENDER = 2'd2
    } state_t;

    // Row r of a glyph word; row 0 sits in the top bits, MSB = leftmost pixel.
    function automatic logic [GLYPH_W-1:0] glyph_row(
        input logic [GLYPH_BITS-1:0] glyph,
        input logic [2:0]            r
    );
        return glyph[GLYPH_BITS - 1 - GLYPH_W * int'(r) -: GLYPH_W];
    endfunction

    // Builds a glyph word from seven drawn rows; row 7 is always blank.
    function automatic logic [GLYPH_BITS-1:0] pack_glyph(
        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] r3, input logic [4:0] r4, input logic [4:0] r5,
        input logic [4:0] r6
    );
        return {r0, r1, r2, r3, r4, r5, r6, 5'h00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/t03_font_rom.sv
// ============================================================================
//  Module   : t03_font_rom
//  Purpose  : 5x8 font ROM for codes 0x20..0x5F, synchronous read with one
//             cycle of latency. Unsupported addresses return an all-zero glyph.
//  Ports    : clk  - clock
//             en   - read enable (data holds when low)
//             addr - 7-bit character address
//             data - 40-bit glyph, row 0 in bits [39:35]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t03_font_rom
    import t03_text_pkg::*;
(
    input  logic                  clk,
    input  logic                  en,
    input  logic [6:0]            addr,
    output logic [GLYPH_BITS-1:0] data
);

    function automatic logic [GLYPH_BITS-1:0] glyph_lut(input logic [6:0] a);
        case (a)
            7'h20: glyph_lut = pack_glyph(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
            7'h21: glyph_lut = pack_glyph(5'h04, 5'h04, 5'h04, 5'h04, 5'h00, 5'h00, 5'h04);
            7'h22: glyph_lut = pack_glyph(5'h0A, 5'h0A, 5'h0A, 5'h00, 5'h00, 5'h00, 5'h00);
            7'h23: glyph_lut = pack_glyph(5'h0A, 5'h0A, 5'h1F, 5'h0A, 5'h1F, 5'h0A, 5'h0A);
            7'h24: glyph_lut = pack_glyph(5'h04, 5'h0F, 5'h14, 5'h0E, 5'h05, 5'h1E, 5'h04);
            7'h25: glyph_lut = pack_glyph(5'h18, 5'h19, 5'h02, 5'h04, 5'h08, 5'h13, 5'h03);
            7'h26: glyph_lut = pack_glyph(5'h0C, 5'h12, 5'h14, 5'h08, 5'h15, 5'h12, 5'h0D);
            7'h27: glyph_lut = pack_glyph(5'h0C, 5'h04, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00);
            7'h28: glyph_lut = pack_glyph(5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h04, 5'h02);
            7'h29: glyph_lut = pack_glyph(5'h08, 5'h04, 5'h02, 5'h02, 5'h02, 5'h04, 5'h08);
            7'h2A: glyph_lut = pack_glyph(5'h00, 5'h04, 5'h15, 5'h0E, 5'h15, 5'h04, 5'h00);
            7'h2B: glyph_lut = pack_glyph(5'h00, 5'h04, 5'h04, 5'h1F, 5'h04, 5'h04, 5'h00);
            7'h2C: glyph_lut = pack_glyph(5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h04, 5'h08);
            7'h2D: glyph_lut = pack_glyph(5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
            7'h2E: glyph_lut = pack_glyph(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0C);
            7'h2F: glyph_lut = pack_glyph(5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00);
            7'h30: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E);
            7'h31: glyph_lut = pack_glyph(5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E);
            7'h32: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F);
            7'h33: glyph_lut = pack_glyph(5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E);
            7'h34: glyph_lut = pack_glyph(5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02);
            7'h35: glyph_lut = pack_glyph(5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E);
            7'h36: glyph_lut = pack_glyph(5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E);
            7'h37: glyph_lut = pack_glyph(5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08);
            7'h38: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E);
            7'h39: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C);
            7'h3A: glyph_lut = pack_glyph(5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00);
            7'h3B: glyph_lut = pack_glyph(5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h04, 5'h08);
            7'h3C: glyph_lut = pack_glyph(5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02);
            7'h3D: glyph_lut = pack_glyph(5'h00, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h00);
            7'h3E: glyph_lut = pack_glyph(5'h08, 5'h04, 5'h02, 5'h01, 5'h02, 5'h04, 5'h08);
            7'h3F: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h00, 5'h04);
            7'h40: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h01, 5'h0D, 5'h15, 5'h15, 5'h0E);
            7'h41: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11);
            7'h42: glyph_lut = pack_glyph(5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E);
            7'h43: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E);
            7'h44: glyph_lut = pack_glyph(5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C);
            7'h45: glyph_lut = pack_glyph(5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F);
            7'h46: glyph_lut = pack_glyph(5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10);
            7'h47: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F);
            7'h48: glyph_lut = pack_glyph(5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11);
            7'h49: glyph_lut = pack_glyph(5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E);
            7'h4A: glyph_lut = pack_glyph(5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C);
            7'h4B: glyph_lut = pack_glyph(5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11);
            7'h4C: glyph_lut = pack_glyph(5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F);
            7'h4D: glyph_lut = pack_glyph(5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11);
            7'h4E: glyph_lut = pack_glyph(5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11);
            7'h4F: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E);
            7'h50: glyph_lut = pack_glyph(5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10);
            7'h51: glyph_lut = pack_glyph(5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D);
            7'h52: glyph_lut = pack_glyph(5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11);
            7'h53: glyph_lut = pack_glyph(5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E);
            7'h54: glyph_lut = pack_glyph(5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04);
            7'h55: glyph_lut = pack_glyph(5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E);
            7'h56: glyph_lut = pack_glyph(5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04);
            7'h57: glyph_lut = pack_glyph(5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A);
            7'h58: glyph_lut = pack_glyph(5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11);
            7'h59: glyph_lut = pack_glyph(5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04);
            7'h5A: glyph_lut = pack_glyph(5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F);
            7'h5B: glyph_lut = pack_glyph(5'h0E, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h0E);
            7'h5C: glyph_lut = pack_glyph(5'h00, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h00);
            7'h5D: glyph_lut = pack_glyph(5'h0E, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h0E);
            7'h5E: glyph_lut = pack_glyph(5'h04, 5'h0A, 5'h11, 5'h00, 5'h00, 5'h00, 5'h00);
            7'h5F: glyph_lut = pack_glyph(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F);
            default: glyph_lut = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (en) begin
            data <= glyph_lut(addr);
        end
    end

endmodule

`default_nettype wire

// File: rtl/t03_text_rasterizer.sv
// ============================================================================
//  Module   : t03_text_rasterizer
//  Purpose  : Renders a stream of character codes through a 5x8 font into a
//             double-buffered 108x8 monochrome bitmap. The work buffer is
//             copied to the displayed bitmap on frame_start after a commit.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             char_valid/ready - character handshake, char_code = ASCII code
//             clear            - blank work buffer, cursor and overflow
//             commit           - work buffer is complete, swap on next frame
//             frame_start      - start of vertical blank (swap point)
//             text             - displayed bitmap, pixel (r,c) at 863-(r*108+c)
//             busy             - FSM not idle
//             overflow         - sticky, a code was dropped on a full line
//  Options  : T03_BACKSPACE_EN - code 0x08 moves the cursor back one cell and
//                                blanks that cell
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t03_text_rasterizer
    import t03_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_code,
    input  logic              clear,
    input  logic              commit,
    input  logic              frame_start,
    output logic [TEXT_W-1:0] text,
    output logic              busy,
    output logic              overflow
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CUR_W-1:0]        r_cursor;
    logic [2:0]              r_row;
    logic                    r_code_hi;
    logic [GLYPH_BITS-1:0]   r_glyph;
    logic [TEXT_W-1:0]       r_work;
    logic [TEXT_W-1:0]       r_text;
    logic                    r_overflow;
    logic                    r_commit_pending;
    logic [GLYPH_BITS-1:0]   w_rom_data;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_last_row;
    logic                    w_swap;
    logic [9:0]              w_wr_base;
`ifdef T03_BACKSPACE_EN
    logic                    w_bs;
`endif

    // The ROM sees only the low 7 bits; codes with bit 7 set are blanked
    // after the lookup so they cannot alias onto 0x20..0x5F.
    t03_font_rom u_font_rom (
        .clk  (clk),
        .en   (w_accept),
        .addr (char_code[6:0]),
        .data (w_rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_last_row   = 1'b0;
`ifdef T03_BACKSPACE_EN
        w_bs         = 1'b0;
`endif
        char_ready   = (r_state == IDLE);
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (char_valid) begin
`ifdef T03_BACKSPACE_EN
                    // Backspace is checked first so a full line can still be edited.
                    if (char_code == BS_CODE) begin
                        w_bs = 1'b1;
                    end else
`endif
                    if (r_cursor == CUR_W'(CHARS)) begin
                        w_drop = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_state_next = LOOKUP;
                    end
                end
            end
            LOOKUP: w_state_next = RENDER;
            RENDER: begin
                if (r_row == 3'(ROWS - 1)) begin
                    w_last_row   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (clear) begin
            w_state_next = IDLE;
            w_accept     = 1'b0;
            w_drop       = 1'b0;
`ifdef T03_BACKSPACE_EN
            w_bs         = 1'b0;
`endif
        end
    end

    assign w_swap    = frame_start && (r_commit_pending || commit) &&
                       (r_state == IDLE) && !clear;
    assign w_wr_base = 10'(TEXT_W - 1 - int'(r_row) * LINE_W - int'(r_cursor) * CELL_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_text           <= '0;
            r_work           <= '0;
            r_cursor         <= '0;
            r_row            <= '0;
            r_code_hi        <= 1'b0;
            r_glyph          <= '0;
            r_overflow       <= 1'b0;
            r_commit_pending <= 1'b0;
        end else begin
            if (w_swap) begin
                r_text <= r_work;
            end
            // A commit arriving with the swap is consumed by that swap.
            if (w_swap) begin
                r_commit_pending <= 1'b0;
            end else if (commit) begin
                r_commit_pending <= 1'b1;
            end

            if (clear) begin
                r_work     <= '0;
                r_cursor   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_accept) begin
                    r_code_hi <= char_code[7];
                end
                if (r_state == LOOKUP) begin
                    r_glyph <= r_code_hi ? '0 : w_rom_data;
                    r_row   <= '0;
                end
                if (r_state == RENDER) begin
                    r_work[w_wr_base -: CELL_W] <= {glyph_row(r_glyph, r_row), 1'b0};
                    r_row <= r_row + 3'd1;
                    if (w_last_row) begin
                        r_cursor <= r_cursor + CUR_W'(1);
                    end
                end
`ifdef T03_BACKSPACE_EN
                if (w_bs && (r_cursor != '0)) begin
                    r_cursor <= r_cursor - CUR_W'(1);
                    for (int r = 0; r < ROWS; r++) begin
                        r_work[10'(TEXT_W - 1 - r * LINE_W - (int'(r_cursor) - 1) * CELL_W) -: CELL_W] <= '0;
                    end
                end
`endif
            end
        end
    end

    assign text     = r_text;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
